hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline. It resolves the hazards that register forwarding cannot resolve.
- Load-use hazards: inserts one bubble.
- Taken branches: flushes IF/ID and ID/EX.
- Multi-cycle data-memory access: freezes the whole pipeline until the memory is ready, with timeout detection.
- Sits beside the forwarding logic in ID/EX. Drives the pipeline-register write enables, bubble/flush controls and the PC write enable.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_error sets; must be >= 1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- IF_ID_Rs1  input  5  rs1 field of the instruction in ID.
- IF_ID_Rs2  input  5  rs2 field of the instruction in ID.
- ID_Uses_Rs1  input  1  ID instruction reads rs1.
- ID_Uses_Rs2  input  1  ID instruction reads rs2.
- ID_EX_Rd  input  5  rd of the instruction in EX.
- ID_EX_MemRead  input  1  EX instruction is a load.
- EX_Branch_Taken  input  1  branch/jump in EX resolved taken.
- EX_MEM_MemReq  input  1  MEM-stage instruction accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register enable.
- ID_EX_Write  output  1  ID/EX register enable.
- EX_MEM_Write  output  1  EX/MEM register enable.
- MEM_WB_Write  output  1  MEM/WB register enable.
- ID_EX_Bubble  output  1  load NOP (all control zero) into ID/EX.
- IF_ID_Flush  output  1  clear IF/ID to NOP.
- ID_EX_Flush  output  1  clear ID/EX to NOP.
- mem_error  output  1  sticky memory-timeout flag.
- stall_count  output  CNT_W  saturating count of stall/freeze cycles.
- flush_count  output  CNT_W  saturating count of branch flush events.

Behaviour:
- State register: RUN or MEM_WAIT. A wait counter wcnt is 8 bits minimum and wide enough for MEM_TIMEOUT.
- Control outputs are combinational from state plus inputs. Counters, mem_error, state and wcnt are registered.
- Reset, while rst=1:
  - all five write enables 0; IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Bubble=0.
  - next state RUN; wcnt, stall_count and flush_count 0; mem_error 0.
  - Reset mid-MEM_WAIT abandons the wait.
- Default (no hazard): all write enables 1; bubble and flushes 0.
- Priority, highest first: freeze > branch flush > load-use.
- Freeze condition:
  - In RUN: EX_MEM_MemReq=1 and mem_ready=0.
  - In MEM_WAIT: mem_ready=0.
  - Effect: all five write enables 0, bubble and flushes 0.
  - RUN->MEM_WAIT on a freeze in RUN. MEM_WAIT->RUN on the cycle mem_ready=1.
  - The release cycle is evaluated as RUN (branch or load-use may act in the same cycle).
  - A memory op with mem_ready=1 in the same cycle causes no freeze and no state change.
- Branch flush (EX_Branch_Taken=1, no freeze):
  - IF_ID_Flush=1, ID_EX_Flush=1, all write enables 1.
  - flush_count +1, saturating at all-ones.
  - A branch during a freeze is not lost: EX is held, so it is acted on at release.
- Load-use, when all of the following hold with no freeze and no branch:
  - ID_EX_MemRead=1 and ID_EX_Rd!=0;
  - (ID_Uses_Rs1 and ID_EX_Rd==IF_ID_Rs1) or (ID_Uses_Rs2 and ID_EX_Rd==IF_ID_Rs2).
  - Effect: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; the other enables stay 1.
  - Exactly one bubble per load, because the bubble clears ID_EX_MemRead.
  - rd=x0 never stalls.
- stall_count: +1 on every freeze or load-use cycle, saturating at all-ones.
- Timeout:
  - wcnt resets to 0 on entry to MEM_WAIT and increments each MEM_WAIT cycle with mem_ready=0.
  - When wcnt reaches MEM_TIMEOUT, mem_error sets and stays set until rst.
  - The freeze continues regardless of mem_error.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5, ID_Uses_Rs2=1 -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle; stall_count 0->1. Same with Rd=0 -> no stall.
- Unused operand: Rd=7 matches IF_ID_Rs1=7 but ID_Uses_Rs1=0 -> no stall.
- Branch: EX_Branch_Taken=1 for one cycle -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1; flush_count=1.
- Memory wait: EX_MEM_MemReq=1, mem_ready low 3 cycles then high -> all enables 0 for 3 cycles, 1 on the 4th; stall_count=3; state back to RUN.
- Freeze with branch: MemReq=1, mem_ready=0, EX_Branch_Taken=1 held -> no flush during freeze; flushes asserted on the release cycle; flush_count=1.
- Timeout and reset: MEM_TIMEOUT=4, mem_ready held 0 -> mem_error=1 after 4 wait cycles and stays set; rst for 1 cycle -> mem_error=0, counters 0, state RUN.

Source files
------------

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Stall/flush controller for the 5-stage RISC-V pipeline.
//               It handles the hazards that register forwarding cannot
//               resolve:
//                 - load-use        : one bubble into ID/EX, PC and IF/ID held
//                 - taken branch    : IF/ID and ID/EX flushed
//                 - slow data memory: whole pipeline frozen until mem_ready,
//                                     with a sticky timeout flag
//               Priority, highest first: freeze > branch flush > load-use.
// Ports       :
//   clk, rst               clock (rising edge), synchronous active-high reset
//   IF_ID_Rs1/Rs2          source register fields of the instruction in ID
//   ID_Uses_Rs1/Rs2        ID instruction actually reads rs1 / rs2
//   ID_EX_Rd               destination register of the instruction in EX
//   ID_EX_MemRead          EX instruction is a load
//   EX_Branch_Taken        branch/jump in EX resolved taken
//   EX_MEM_MemReq          MEM-stage instruction accesses data memory
//   mem_ready              data memory completes the access this cycle
//   PC_Write .. MEM_WB_Write  pipeline-register / PC write enables
//   ID_EX_Bubble           load a NOP (all control zero) into ID/EX
//   IF_ID_Flush/ID_EX_Flush   clear the register to a NOP
//   mem_error              sticky memory-timeout flag
//   stall_count            saturating count of freeze and load-use cycles
//   flush_count            saturating count of branch flush events
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IF_ID_Rs1,
   input  logic [4:0]       IF_ID_Rs2,
   input  logic             ID_Uses_Rs1,
   input  logic             ID_Uses_Rs2,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             ID_EX_MemRead,
   input  logic             EX_Branch_Taken,
   input  logic             EX_MEM_MemReq,
   input  logic             mem_ready,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // Wait counter is at least 8 bits and always wide enough to hold MEM_TIMEOUT.
   localparam int c_WCNT_RAW = $clog2(MEM_TIMEOUT + 1);
   localparam int c_WCNT_W   = (c_WCNT_RAW > 8) ? c_WCNT_RAW : 8;

   // Timeout limit extended by one bit so the incremented count never wraps.
   localparam logic [c_WCNT_W:0] c_TIMEOUT = (c_WCNT_W + 1)'(MEM_TIMEOUT);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_WCNT_W-1:0]  r_wcnt;
   logic [c_WCNT_W:0]    w_wcnt_inc;
   logic                 r_mem_error;
   logic [CNT_W-1:0]     r_stall_count;
   logic [CNT_W-1:0]     r_flush_count;

   logic                 w_freeze;
   logic                 w_hit_rs1;
   logic                 w_hit_rs2;
   logic                 w_load_use;
   logic                 w_stall_evt;
   logic                 w_flush_evt;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   // A register only conflicts if the ID instruction actually reads it; x0
   // is hard-wired to zero, so a load targeting it never needs a stall.
   assign w_hit_rs1  = ID_Uses_Rs1 && (ID_EX_Rd == IF_ID_Rs1);
   assign w_hit_rs2  = ID_Uses_Rs2 && (ID_EX_Rd == IF_ID_Rs2);
   assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) && (w_hit_rs1 || w_hit_rs2);

   // In RUN a freeze needs an outstanding request; once in MEM_WAIT the
   // request is already latched in EX/MEM, so only mem_ready matters.
   // The cycle mem_ready rises is therefore treated exactly like RUN.
   assign w_wcnt_inc = {1'b0, r_wcnt} + 1'b1;

   // ------------------------------------------------------------------------
   // Next state and control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_freeze     = 1'b0;
      w_stall_evt  = 1'b0;
      w_flush_evt  = 1'b0;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      MEM_WB_Write = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;

      case (r_state)
         ST_RUN:      w_freeze = EX_MEM_MemReq && !mem_ready;
         ST_MEM_WAIT: w_freeze = !mem_ready;
         default:     w_freeze = 1'b0;
      endcase

      w_state_nxt = w_freeze ? ST_MEM_WAIT : ST_RUN;

      if (rst) begin
         // Hold everything and scrub the front of the pipe while in reset.
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Write = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         w_state_nxt  = ST_RUN;
      end else if (w_freeze) begin
         // A taken branch seen here stays in EX because ID/EX is held, so it
         // is acted on at the release cycle rather than being dropped.
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Write = 1'b0;
         w_stall_evt  = 1'b1;
      end else if (EX_Branch_Taken) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         w_flush_evt  = 1'b1;
      end else if (w_load_use) begin
         // The bubble clears ID_EX_MemRead, so each load stalls exactly once.
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
         w_stall_evt  = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State, wait counter, timeout flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_wcnt      <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RUN) begin
            if (w_freeze) begin
               r_wcnt <= '0;
            end
         end else if (!mem_ready) begin
            // Count saturates at the limit; the flag is raised on the edge
            // where the count reaches it and then sticks until reset.
            if (w_wcnt_inc <= c_TIMEOUT) begin
               r_wcnt <= w_wcnt_inc[c_WCNT_W-1:0];
            end
            if (w_wcnt_inc >= c_TIMEOUT) begin
               r_mem_error <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Saturating event counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall_evt && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
         end
         if (w_flush_evt && (r_flush_count != {CNT_W{1'b1}})) begin
            r_flush_count <= r_flush_count + 1'b1;
         end
      end
   end

   assign mem_error   = r_mem_error;
   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;

endmodule
`default_nettype wire
